// File: rtl/masked_share_if.sv
// Handshake and data bundle between the encoder, its upstream source of
// unmasked bits, and the downstream masked AND stage.
interface masked_share_if #(
  parameter int LFSR_WIDTH = 32
);
  logic                  i_valid;
  logic                  o_ready;
  logic                  i_a;
  logic                  i_b;
  logic                  i_reseed;
  logic [LFSR_WIDTH-1:0] i_seed;
  logic                  o_valid;
  logic                  i_ready;
  logic                  o_a0;
  logic                  o_a1;
  logic                  o_b0;
  logic                  o_b1;
  logic                  o_rN;

  // Environment side: drives operands, reseed and downstream ready.
  modport master (
    output i_valid, i_a, i_b, i_reseed, i_seed, i_ready,
    input  o_ready, o_valid, o_a0, o_a1, o_b0, o_b1, o_rN
  );

  // Encoder side.
  modport slave (
    input  i_valid, i_a, i_b, i_reseed, i_seed, i_ready,
    output o_ready, o_valid, o_a0, o_a1, o_b0, o_b1, o_rN
  );
endinterface

// File: rtl/masked_share_encoder.sv
// Splits unmasked bits a and b into two Boolean shares each and supplies a
// fresh mask bit for the downstream masked AND. Masks come from a Galois
// LFSR that advances three steps per accepted transaction, so no mask bit
// is ever reused.
//
// state  | meaning
// WARMUP | LFSR stepping only, o_ready low, wcnt counts down to zero
// RUN    | accepting operands under valid/ready
module masked_share_encoder #(
  parameter int                    LFSR_WIDTH    = 32,
  parameter logic [LFSR_WIDTH-1:0] TAPS          = 32'h80200003,
  parameter logic [LFSR_WIDTH-1:0] SEED          = 32'hACE12468,
  parameter int                    WARMUP_CYCLES = 16
) (
  input logic            clk,
  input logic            rst_n,
  masked_share_if.slave  bus
);

  localparam int WCNT_W = (WARMUP_CYCLES < 1) ? 1 : $clog2(WARMUP_CYCLES + 1);
  localparam logic [WCNT_W-1:0] WCNT_INIT = WCNT_W'(WARMUP_CYCLES);

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
  logic [LFSR_WIDTH-1:0] lfsr_q;
  logic [LFSR_WIDTH-1:0] lfsr_adv;
  logic [LFSR_WIDTH-1:0] seed_sel;
  logic                  ready;
  logic                  accept;
  logic                  warm_step;
  logic                  valid_q;
  logic                  a0_q, a1_q, b0_q, b1_q, rn_q;

  function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : '0);
  endfunction

  // Three chained steps: one fresh bit each for ma, mb and r.
  assign lfsr_adv = lfsr_step(lfsr_step(lfsr_step(lfsr_q)));

  // All-zero is the LFSR lock-up state, so a zero seed falls back to SEED.
  assign seed_sel = (bus.i_seed == '0) ? SEED : bus.i_seed;

  // State and warm-up counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= WARMUP;
      wcnt_q  <= WCNT_INIT;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next-state, warm-up countdown and handshake decode.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    ready     = 1'b0;
    warm_step = 1'b0;
    // Reseed wins over accept, so ready is withheld to avoid dropping a beat.
    if (state_q == RUN && !bus.i_reseed) begin
      ready = !valid_q || bus.i_ready;
    end
    accept = bus.i_valid && ready;
    if (bus.i_reseed) begin
      state_d = WARMUP;
      wcnt_d  = WCNT_INIT;
    end else if (state_q == WARMUP) begin
      if (wcnt_q == '0) begin
        state_d = RUN;
      end else begin
        wcnt_d    = wcnt_q - WCNT_W'(1);
        warm_step = 1'b1;
      end
    end
  end

  // LFSR, share registers and output valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q  <= SEED;
      valid_q <= 1'b0;
      a0_q    <= 1'b0;
      a1_q    <= 1'b0;
      b0_q    <= 1'b0;
      b1_q    <= 1'b0;
      rn_q    <= 1'b0;
    end else if (bus.i_reseed) begin
      lfsr_q  <= seed_sel;
      valid_q <= 1'b0;
      a0_q    <= 1'b0;
      a1_q    <= 1'b0;
      b0_q    <= 1'b0;
      b1_q    <= 1'b0;
      rn_q    <= 1'b0;
    end else begin
      if (warm_step || accept) begin
        lfsr_q <= lfsr_adv;
      end
      if (accept) begin
        valid_q <= 1'b1;
        a0_q    <= bus.i_a ^ lfsr_q[0];
        a1_q    <= lfsr_q[0];
        b0_q    <= bus.i_b ^ lfsr_q[1];
        b1_q    <= lfsr_q[1];
        rn_q    <= lfsr_q[2];
      end else if (valid_q && bus.i_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.o_ready = ready;
  assign bus.o_valid = valid_q;
  assign bus.o_a0    = a0_q;
  assign bus.o_a1    = a1_q;
  assign bus.o_b0    = b0_q;
  assign bus.o_b1    = b1_q;
  assign bus.o_rN    = rn_q;

endmodule

// File: tb/tb_masked_share_encoder.sv
// Bench for masked_share_encoder: a directed vector table on an 8-bit LFSR
// instance with no warm-up, hand sequences for stall, reseed and reset, a
// warm-up instance, and a long random run against a reference LFSR model.
module tb_masked_share_encoder;

  localparam logic [7:0] TAPS8 = 8'hB8;
  localparam logic [7:0] SEED8 = 8'h01;

  logic clk;
  logic rst0_n;
  logic rst1_n;

  masked_share_if #(.LFSR_WIDTH(8)) bus0 ();
  masked_share_if #(.LFSR_WIDTH(8)) bus1 ();

  masked_share_encoder #(
    .LFSR_WIDTH(8), .TAPS(TAPS8), .SEED(SEED8), .WARMUP_CYCLES(0)
  ) dut0 (
    .clk(clk), .rst_n(rst0_n), .bus(bus0)
  );

  masked_share_encoder #(
    .LFSR_WIDTH(8), .TAPS(TAPS8), .SEED(SEED8), .WARMUP_CYCLES(4)
  ) dut1 (
    .clk(clk), .rst_n(rst1_n), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // {o_valid, o_a0, o_a1, o_b0, o_b1, o_rN}
  typedef struct {
    logic       valid;
    logic       a;
    logic       b;
    logic       ready;
    logic       ex_oready;
    logic [5:0] ex_out;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [7:0] mstep(input logic [7:0] s);
    logic [7:0] t;
    t = {1'b0, s[7:1]};
    if (s[0]) t = t ^ TAPS8;
    return t;
  endfunction

  function automatic logic [7:0] madv(input logic [7:0] s);
    return mstep(mstep(mstep(s)));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] outs0();
    return {bus0.o_valid, bus0.o_a0, bus0.o_a1, bus0.o_b0, bus0.o_b1, bus0.o_rN};
  endfunction

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] m0;
  logic [7:0] m1;
  logic [5:0] mo;
  logic [5:0] hold;
  logic       ra, rb, rv, rr, exp_ready;
  logic       acc_a, acc_b;

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 6'b1_0_1_1_0_0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6'b1_1_0_1_1_1};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'b0_1_0_1_1_1};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 6'b1_1_1_1_0_0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'b1_0_0_1_1_0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 6'b1_1_0_0_1_0};

    rst0_n = 1'b0;
    rst1_n = 1'b0;
    bus0.i_valid = 1'b0; bus0.i_a = 1'b0; bus0.i_b = 1'b0;
    bus0.i_reseed = 1'b0; bus0.i_seed = 8'h00; bus0.i_ready = 1'b0;
    bus1.i_valid = 1'b1; bus1.i_a = 1'b1; bus1.i_b = 1'b0;
    bus1.i_reseed = 1'b0; bus1.i_seed = 8'h00; bus1.i_ready = 1'b1;
    repeat (3) edge_wait();
    chk("reset0_outputs", outs0(), 6'b0);
    chk("reset0_ready", bus0.o_ready, 1'b0);
    chk("reset1_valid", bus1.o_valid, 1'b0);

    // Warm-up of 4: ready low for exactly four cycles after release.
    rst1_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      edge_wait();
      chk($sformatf("warmup_ready_%0d", k), bus1.o_ready, (k == 5) ? 1'b1 : 1'b0);
      chk($sformatf("warmup_valid_%0d", k), bus1.o_valid, 1'b0);
    end
    m1 = SEED8;
    repeat (4) m1 = madv(m1);
    edge_wait();
    chk("warmup_first_accept",
        {bus1.o_valid, bus1.o_a0, bus1.o_a1, bus1.o_b0, bus1.o_b1, bus1.o_rN},
        {1'b1, 1'b1 ^ m1[0], m1[0], 1'b0 ^ m1[1], m1[1], m1[2]});
    bus1.i_valid = 1'b0;

    // Directed table on the no-warm-up instance.
    rst0_n = 1'b1;
    edge_wait();
    m0 = SEED8;
    for (int i = 0; i < 6; i++) begin
      bus0.i_valid = vecs[i].valid;
      bus0.i_a     = vecs[i].a;
      bus0.i_b     = vecs[i].b;
      bus0.i_ready = vecs[i].ready;
      #1;
      chk($sformatf("vec%0d_ready", i), bus0.o_ready, vecs[i].ex_oready);
      if (vecs[i].valid && vecs[i].ex_oready) m0 = madv(m0);
      edge_wait();
      chk($sformatf("vec%0d_out", i), outs0(), vecs[i].ex_out);
    end
    chk("table_lfsr_model", m0, 8'h57);

    // Stall: outputs frozen and ready low while downstream holds off.
    hold = outs0();
    for (int k = 0; k < 3; k++) begin
      bus0.i_valid = 1'b1; bus0.i_a = 1'b0; bus0.i_b = 1'b1; bus0.i_ready = 1'b0;
      #1;
      chk($sformatf("stall%0d_ready", k), bus0.o_ready, 1'b0);
      edge_wait();
      chk($sformatf("stall%0d_hold", k), outs0(), hold);
    end
    // Release: back-to-back accepts with no bubble.
    for (int k = 0; k < 4; k++) begin
      ra = k[0]; rb = k[1];
      bus0.i_valid = 1'b1; bus0.i_a = ra; bus0.i_b = rb; bus0.i_ready = 1'b1;
      #1;
      chk($sformatf("b2b%0d_ready", k), bus0.o_ready, 1'b1);
      mo = {1'b1, ra ^ m0[0], m0[0], rb ^ m0[1], m0[1], m0[2]};
      m0 = madv(m0);
      edge_wait();
      chk($sformatf("b2b%0d_out", k), outs0(), mo);
    end

    // Reseed with zero while output pending: flush and fall back to SEED.
    bus0.i_reseed = 1'b1; bus0.i_seed = 8'h00; bus0.i_valid = 1'b1; bus0.i_ready = 1'b0;
    #1;
    chk("reseed_blocks_ready", bus0.o_ready, 1'b0);
    edge_wait();
    bus0.i_reseed = 1'b0;
    chk("reseed_flush", outs0(), 6'b0);
    bus0.i_valid = 1'b1; bus0.i_a = 1'b1; bus0.i_b = 1'b1; bus0.i_ready = 1'b1;
    #1;
    chk("reseed_warmup_ready", bus0.o_ready, 1'b0);
    edge_wait();
    chk("reseed_no_accept", bus0.o_valid, 1'b0);
    #1;
    chk("reseed_run_ready", bus0.o_ready, 1'b1);
    edge_wait();
    chk("reseed_seed_out", outs0(), 6'b1_0_1_1_0_0);

    // Reseed with a nonzero value lands directly on that state.
    bus0.i_reseed = 1'b1; bus0.i_seed = 8'h2E; bus0.i_valid = 1'b0;
    edge_wait();
    bus0.i_reseed = 1'b0;
    edge_wait();
    bus0.i_valid = 1'b1; bus0.i_a = 1'b1; bus0.i_b = 1'b0;
    edge_wait();
    chk("reseed_2e_out", outs0(), 6'b1_1_0_1_1_1);

    // Reset while an output is pending discards it.
    bus0.i_valid = 1'b0; bus0.i_ready = 1'b0;
    rst0_n = 1'b0;
    edge_wait();
    chk("midreset_flush", outs0(), 6'b0);
    rst0_n = 1'b1;
    edge_wait();

    // Random traffic against the reference model.
    m0 = SEED8;
    mo = 6'b0;
    acc_a = 1'b0;
    acc_b = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      rv = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 3) != 0);
      ra = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      bus0.i_valid = rv; bus0.i_a = ra; bus0.i_b = rb; bus0.i_ready = rr;
      exp_ready = !mo[5] || rr;
      #1;
      chk("rand_ready", bus0.o_ready, exp_ready);
      if (rv && exp_ready) begin
        mo = {1'b1, ra ^ m0[0], m0[0], rb ^ m0[1], m0[1], m0[2]};
        m0 = madv(m0);
        acc_a = ra;
        acc_b = rb;
      end else if (mo[5] && rr) begin
        mo[5] = 1'b0;
      end
      edge_wait();
      chk("rand_out", outs0(), mo);
      if (bus0.o_valid) begin
        chk("rand_xor_ab", {bus0.o_a0 ^ bus0.o_a1, bus0.o_b0 ^ bus0.o_b1}, {acc_a, acc_b});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
